// File: rtl/trigger_pulse_gen_pkg.sv
// Shared definitions for the trigger pulse generator: default field widths
// and FSM state encodings.
package trigger_pulse_gen_pkg;

  localparam int unsigned DEF_WIDTH     = 16;
  localparam int unsigned DEF_NUM_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    HIGH = ST_HIGH,
    LOW  = ST_LOW
  } state_t;

endpackage

// File: rtl/trigger_pulse_gen.sv
// Armed, triggered pulse-train generator: on an accepted trigger emits
// num_pulses+1 pulses of width+1 high cycles separated by gap+1 low cycles.
module trigger_pulse_gen
  import trigger_pulse_gen_pkg::*;
#(
  parameter int unsigned pWIDTH     = DEF_WIDTH,
  parameter int unsigned pNUM_WIDTH = DEF_NUM_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  arm,
  input  logic                  trig_in,
  input  logic [pNUM_WIDTH-1:0] num_pulses,
  input  logic [pWIDTH-1:0]     width,
  input  logic [pWIDTH-1:0]     gap,
  input  logic                  clear_missed,
  output logic                  pulse_out,
  output logic                  busy,
  output logic                  done,
  output logic                  missed
);

  state_t                  state, state_nxt;
  logic [pWIDTH-1:0]       cnt, cnt_nxt;
  logic [pWIDTH-1:0]       width_q, width_nxt;
  logic [pWIDTH-1:0]       gap_q, gap_nxt;
  logic [pNUM_WIDTH-1:0]   left_q, left_nxt;
  logic                    done_nxt;
  logic                    missed_nxt;

  // State, shared phase counter, latched configuration and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      width_q   <= '0;
      gap_q     <= '0;
      left_q    <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      missed    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      width_q   <= width_nxt;
      gap_q     <= gap_nxt;
      left_q    <= left_nxt;
      pulse_out <= (state_nxt == HIGH);
      busy      <= (state_nxt != IDLE);
      done      <= done_nxt;
      missed    <= missed_nxt;
    end
  end

  // Next-state logic; outputs are decoded from state_nxt so they line up with state
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    width_nxt  = width_q;
    gap_nxt    = gap_q;
    left_nxt   = left_q;
    done_nxt   = 1'b0;
    // Set wins over clear so a trigger coinciding with a clear is not lost
    missed_nxt = (trig_in && (state != IDLE)) || (missed && !clear_missed);

    case (state)
      IDLE: begin
        if (arm && trig_in) begin
          state_nxt = HIGH;
          cnt_nxt   = width;
          width_nxt = width;
          gap_nxt   = gap;
          left_nxt  = num_pulses;
        end
      end
      HIGH: begin
        if (!arm) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          if (left_q == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = LOW;
            cnt_nxt   = gap_q;
            left_nxt  = left_q - pNUM_WIDTH'(1);
          end
        end else begin
          cnt_nxt = cnt - pWIDTH'(1);
        end
      end
      LOW: begin
        if (!arm) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = HIGH;
          cnt_nxt   = width_q;
        end else begin
          cnt_nxt = cnt - pWIDTH'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: doc/trigger_pulse_gen.md
TRIGGER_PULSE_GEN -- requirements
Module: trigger_pulse_gen

Interface
REQ-001 Parameter pWIDTH, default 16, bit width of the width and gap fields.
REQ-002 Parameter pNUM_WIDTH, default 8, bit width of the num_pulses field.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 arm  input  1  level; triggers accepted only while high; low aborts any train.
REQ-006 trig_in  input  1  single-cycle pulse from the trigger resync stage, synchronous to clk.
REQ-007 num_pulses  input  pNUM_WIDTH  pulses per train minus one.
REQ-008 width  input  pWIDTH  high time per pulse in cycles, minus one.
REQ-009 gap  input  pWIDTH  low time between pulses in cycles, minus one.
REQ-010 clear_missed  input  1  single-cycle clear of the missed flag.
REQ-011 pulse_out  output  1  registered glitch/pulse train output.
REQ-012 busy  output  1  high while a train is in progress.
REQ-013 done  output  1  single-cycle strobe on normal train completion.
REQ-014 missed  output  1  sticky flag: trigger arrived while not accepted.

Function
REQ-015 The FSM SHALL have states IDLE, HIGH, LOW; busy = (state != IDLE).
REQ-016 In IDLE with arm=1 and trig_in=1, the FSM SHALL latch num_pulses, width and gap, and SHALL enter HIGH.
REQ-017 pulse_out SHALL rise on the cycle after the accepted trig_in (latency 1) and SHALL equal (state == HIGH), registered.
REQ-018 HIGH SHALL last width+1 cycles, and LOW SHALL last gap+1 cycles.
REQ-019 After HIGH: if pulses emitted == latched num_pulses+1 then go to IDLE (no trailing LOW), else go to LOW; after LOW go to HIGH.
REQ-020 done SHALL be high for exactly one cycle: the first cycle after the final HIGH, coincident with pulse_out low and busy low.
REQ-021 Latched configuration SHALL be held for the whole train; input changes mid-train SHALL have no effect until the next accepted trigger.
REQ-022 Counters SHALL be down-counters loaded with width/gap; zero fields give 1-cycle high/low; all-ones fields give 2^pWIDTH cycles, with no overflow or wrap.
REQ-023 trig_in while busy=1 (including the final HIGH cycle) SHALL be ignored and SHALL set missed.
REQ-024 trig_in in IDLE while arm=0 SHALL be ignored and SHALL NOT set missed.
REQ-025 A trigger on the done cycle SHALL be accepted, since the state is IDLE.
REQ-026 arm=0 while busy SHALL force IDLE on the next edge; pulse_out low next cycle; done NOT asserted.
REQ-027 missed SHALL clear on clear_missed; simultaneous set and clear SHALL leave missed=1.

Reset
REQ-028 reset_n low SHALL asynchronously force state=IDLE, counters=0, pulse_out=0, busy=0, done=0, missed=0.
REQ-029 Reset deassertion mid-train SHALL restart in IDLE with no residual pulse and no done.

Structure
REQ-030 FSM state encodings SHALL be localparams in shared package trigger_pulse_gen_pkg; the pWIDTH and pNUM_WIDTH defaults SHALL also live there.
REQ-031 The block SHALL be a single module with no sub-modules; the width/gap counter SHALL be one shared down-counter.

Verification
REQ-032 Scenario: arm=1, num_pulses=0, width=3, gap=X, trig_in at cycle 10 -> pulse_out high in cycles 11-14; done at cycle 15; busy in cycles 11-14.
REQ-033 Scenario: num_pulses=2, width=1, gap=2, trig at cycle 0 -> high in cycles 1-2, 6-7, 11-12; done at cycle 13.
REQ-034 Scenario: second trig_in during the train of REQ-033 at cycle 5 -> train unchanged and missed=1; clear_missed then gives missed=0; set/clear in the same cycle leaves missed=1.
REQ-035 Scenario: trig_in on the done cycle of REQ-032 (cycle 15) -> new pulse high from cycle 16; missed stays 0.
REQ-036 Scenario: arm dropped at cycle 3 of REQ-033 -> pulse_out=0 from cycle 4; no done; busy=0 at cycle 4.
REQ-037 Scenario: reset_n asserted mid-HIGH asynchronously -> pulse_out=0 before the next edge; with arm=0, trig_in is ignored and missed stays 0.
